sdram_port_responder: RTL and testbench

//  Synthesizable responder for the sdram_controller user port (wr_*/rd_*/busy/rd_ready).

---
 rtl/sdram_port_pkg.sv | 33 +++
 rtl/sdram_port_if.sv | 24 ++
 rtl/sdram_port_mem.sv | 22 ++
 rtl/sdram_port_responder.sv | 130 +++++++++++++
 tb/tb_sdram_port_responder.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/sdram_port_pkg.sv
// Shared definitions for the SDRAM port responder: state encoding and sizing helpers.
package sdram_port_pkg;

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_READ    = 3'd3;
  localparam logic [2:0] ST_REFRESH = 3'd4;

  typedef enum logic [2:0] {
    StInit    = ST_INIT,
    StIdle    = ST_IDLE,
    StWrite   = ST_WRITE,
    StRead    = ST_READ,
    StRefresh = ST_REFRESH
  } state_e;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    for (int unsigned w = 1; w < 32; w++) begin
      if ((32'd1 << w) >= value) return w;
    end
    return 32;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdram_port_if.sv
// User-side port of the SDRAM controller: write/read requests, read return and busy.
interface sdram_port_if #(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_enable;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_enable;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic              busy;

  modport master (
    output wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
    input  rd_data, rd_ready, busy
  );

  modport slave (
    input  wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
    output rd_data, rd_ready, busy
  );
endinterface

// File: rtl/sdram_port_mem.sv
// Backing store: 1R1W synchronous RAM with a registered read port.
module sdram_port_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MEM_AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MEM_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] ram [2**MEM_AW];

  // Write port and registered read port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
    rdata <= ram[raddr];
  end

endmodule

// File: rtl/sdram_port_responder.sv
// Stand-in for the SDRAM controller: block-RAM backed, with init, access and refresh timing.
module sdram_port_responder
  import sdram_port_pkg::*;
#(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned INIT_CYCLES = 100,
  parameter int unsigned WR_LAT      = 4,
  parameter int unsigned RD_LAT      = 6,
  parameter int unsigned REF_PERIOD  = 390,
  parameter int unsigned REF_CYCLES  = 8
) (
  input logic        clk,
  input logic        rst_n,
  sdram_port_if.slave port
);

  localparam int unsigned LAT_W  = clog2(max3(WR_LAT, RD_LAT, REF_CYCLES));
  localparam int unsigned INIT_W = clog2(INIT_CYCLES);
  localparam int unsigned REF_W  = clog2(REF_PERIOD + 1);

  state_e              state;
  logic                busy_q;
  logic [LAT_W-1:0]    lat_cnt;
  logic [INIT_W-1:0]   init_cnt;
  logic [REF_W-1:0]    ref_cnt;
  logic [MEM_AW-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [MEM_AW-1:0]   rd_addr_q;
  logic                rd_ready_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic                mem_we;
  logic [MEM_AW-1:0]   mem_raddr;
  logic [DATA_W-1:0]   mem_rdata;
  logic                unused_addr_bits;

  // Upper address bits only alias; they never reach the RAM.
  assign unused_addr_bits = ^{port.wr_addr[ADDR_W-1:MEM_AW], port.rd_addr[ADDR_W-1:MEM_AW]};

  // The write lands on the last busy edge; the read address is presented one edge early
  // (straight from the port when RD_LAT is 1) so the registered RAM output is ready in time.
  always_comb begin
    mem_we    = (state == StWrite) && (lat_cnt == '0);
    mem_raddr = (state == StIdle) ? port.rd_addr[MEM_AW-1:0] : rd_addr_q;
  end

  sdram_port_mem #(
    .DATA_W (DATA_W),
    .MEM_AW (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr_q),
    .wdata (wr_data_q),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Main FSM: init wait, request acceptance with refresh priority, latency countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StInit;
      busy_q     <= 1'b1;
      lat_cnt    <= '0;
      init_cnt   <= '0;
      ref_cnt    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_ready_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_ready_q <= 1'b0;
      unique case (state)
        StInit: begin
          if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
            state   <= StIdle;
            busy_q  <= 1'b0;
            ref_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end
        StIdle: begin
          if (ref_cnt != REF_W'(REF_PERIOD)) ref_cnt <= ref_cnt + REF_W'(1);
          if (ref_cnt == REF_W'(REF_PERIOD)) begin
            state   <= StRefresh;
            busy_q  <= 1'b1;
            lat_cnt <= LAT_W'(REF_CYCLES - 1);
          end else if (port.wr_enable) begin
            state     <= StWrite;
            busy_q    <= 1'b1;
            lat_cnt   <= LAT_W'(WR_LAT - 1);
            wr_addr_q <= port.wr_addr[MEM_AW-1:0];
            wr_data_q <= port.wr_data;
          end else if (port.rd_enable) begin
            state     <= StRead;
            busy_q    <= 1'b1;
            lat_cnt   <= LAT_W'(RD_LAT - 1);
            rd_addr_q <= port.rd_addr[MEM_AW-1:0];
          end
        end
        StWrite, StRead, StRefresh: begin
          if (lat_cnt == '0) begin
            state  <= StIdle;
            busy_q <= 1'b0;
            if (state == StRead) begin
              rd_data_q  <= mem_rdata;
              rd_ready_q <= 1'b1;
            end
            if (state == StRefresh) ref_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        default: begin
          state  <= StInit;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign port.busy     = busy_q;
  assign port.rd_ready = rd_ready_q;
  assign port.rd_data  = rd_data_q;

endmodule

// File: tb/tb_sdram_port_responder.sv
// Directed bench for sdram_port_responder with a read-data scoreboard.
module tb_sdram_port_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int passed = 0;
  int pulses = 0;
  int pushed = 0;
  logic [15:0] sb[$];

  sdram_port_if #(.ADDR_W(25), .DATA_W(16)) bus ();

  sdram_port_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .port  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard side: every rd_ready pulse must match the oldest outstanding read.
  always @(posedge clk) begin
    #1;
    if (bus.rd_ready === 1'b1) begin
      pulses++;
      if (sb.size() == 0) check("rd_ready_unexpected_sb_size", 32'(sb.size()), 32'd1);
      else check("rd_data", 32'(bus.rd_data), 32'(sb.pop_front()));
    end
  end

  // Count consecutive busy cycles starting at the current negedge.
  task automatic busy_run(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_write(input logic [24:0] addr, input logic [15:0] data, output int n);
    bus.wr_addr   = addr;
    bus.wr_data   = data;
    bus.wr_enable = 1'b1;
    @(negedge clk);
    bus.wr_enable = 1'b0;
    busy_run(n);
  endtask

  task automatic do_read(input logic [24:0] addr, input logic [15:0] exp, output int n);
    sb.push_back(exp);
    pushed++;
    bus.rd_addr   = addr;
    bus.rd_enable = 1'b1;
    @(negedge clk);
    bus.rd_enable = 1'b0;
    busy_run(n);
  endtask

  initial begin
    int n;
    int p0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_enable = 1'b0;
    bus.rd_addr = '0;
    bus.rd_enable = 1'b0;

    // Reset values, then init busy window.
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd1);
    check("reset_rd_ready", 32'(bus.rd_ready), 32'd0);
    check("reset_rd_data", 32'(bus.rd_data), 32'd0);
    rst_n = 1'b1;
    busy_run(n);
    check("init_busy_cycles", 32'(n), 32'd100);
    check("init_no_rd_ready", 32'(pulses), 32'd0);

    // Write then read back; a read level raised mid-write is ignored.
    bus.wr_addr = 25'h0;
    bus.wr_data = 16'h3D1A;
    bus.wr_enable = 1'b1;
    @(negedge clk);
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b1;
    @(negedge clk);
    bus.rd_enable = 1'b0;
    busy_run(n);
    check("write_busy_cycles", 32'(n + 1), 32'd4);
    check("ignored_read_no_pulse", 32'(pulses), 32'd0);
    do_read(25'h0, 16'h3D1A, n);
    check("read_busy_cycles", 32'(n), 32'd6);
    check("read_one_pulse", 32'(pulses), 32'd1);

    // Simultaneous write and read to 0x5: write wins, read returns new data.
    sb.push_back(16'hBEEF);
    pushed++;
    bus.wr_addr = 25'h5;
    bus.rd_addr = 25'h5;
    bus.wr_data = 16'hBEEF;
    bus.wr_enable = 1'b1;
    bus.rd_enable = 1'b1;
    @(negedge clk);
    bus.wr_enable = 1'b0;
    busy_run(n);
    check("simul_write_first", 32'(n), 32'd4);
    check("simul_no_early_read", 32'(pulses), 32'd1);
    @(negedge clk);
    bus.rd_enable = 1'b0;
    busy_run(n);
    check("simul_read_cycles", 32'(n), 32'd6);
    check("simul_read_pulse", 32'(pulses), 32'd2);

    // Address aliasing modulo 2**10, plus a known value at 0x7 for the reset test.
    do_write(25'h400, 16'h1234, n);
    check("alias_write_cycles", 32'(n), 32'd4);
    do_write(25'h7, 16'h0777, n);
    do_read(25'h000, 16'h1234, n);
    repeat (3) @(negedge clk);
    check("rd_data_holds", 32'(bus.rd_data), 32'h1234);

    // Let a refresh happen on its own, then time a read to meet the next due edge.
    n = 0;
    while (bus.busy !== 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
    busy_run(n);
    check("refresh_cycles", 32'(n), 32'd8);
    repeat (390) @(negedge clk);
    check("refresh_gap_idle", 32'(bus.busy), 32'd0);
    p0 = pulses;
    sb.push_back(16'h1234);
    pushed++;
    bus.rd_addr = 25'h0;
    bus.rd_enable = 1'b1;
    @(negedge clk);
    busy_run(n);
    check("refresh_before_read", 32'(n), 32'd8);
    check("refresh_no_pulse", 32'(pulses - p0), 32'd0);
    @(negedge clk);
    bus.rd_enable = 1'b0;
    busy_run(n);
    check("read_after_refresh", 32'(n), 32'd6);
    repeat (3) @(negedge clk);
    check("read_after_refresh_single", 32'(pulses - p0), 32'd1);

    // Reset in cycle 2 of a write: the write is dropped.
    bus.wr_addr = 25'h7;
    bus.wr_data = 16'h5555;
    bus.wr_enable = 1'b1;
    @(negedge clk);
    bus.wr_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    p0 = pulses;
    rst_n = 1'b1;
    busy_run(n);
    check("reinit_busy_cycles", 32'(n), 32'd100);
    do_read(25'h7, 16'h0777, n);
    check("post_reset_read_cycles", 32'(n), 32'd6);
    check("post_reset_pulse", 32'(pulses - p0), 32'd1);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("pulse_total", 32'(pulses), 32'(pushed));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
